// File: rtl/count_stream_checker.sv
// Receive-side checker for a free-running count stream: verifies each valid
// sample is the previous value plus one, locks after a run of good increments.
//
//  state    | meaning
//  SEARCH   | no reference yet; next valid sample seeds the expected value
//  ACQUIRE  | counting consecutive correct increments toward lock
//  LOCKED   | stream verified; any break is flagged and counted
module count_stream_checker #(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_count,
    input  logic                 clr_err,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_WIDTH-1:0] err_count,
    output logic [WIDTH-1:0]     expected,
    output logic [1:0]           state
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0]        LOCK_MATCH = MW'(LOCK_COUNT);
    localparam logic [ERR_WIDTH-1:0] ERR_MAX    = '1;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [MW-1:0]          match_q, match_d;
    logic [WIDTH-1:0]       expected_q, expected_d;
    logic [ERR_WIDTH-1:0]   err_count_q, err_count_d;
    logic                   err_pulse_q, err_pulse_d;
    logic                   locked_q, locked_d;

    logic [WIDTH-1:0]       next_expected;
    logic [MW-1:0]          match_inc;
    logic [ERR_WIDTH-1:0]   err_base;
    logic                   in_match;

    assign next_expected = in_count + WIDTH'(1);
    assign match_inc     = match_q + MW'(1);
    assign in_match      = (in_count == expected_q);

    always_comb begin
        state_d     = state_q;
        match_d     = match_q;
        expected_d  = expected_q;
        err_pulse_d = 1'b0;
        // A clear lands before any error counted on the same edge.
        err_base    = clr_err ? '0 : err_count_q;
        err_count_d = err_base;

        if (in_valid) begin
            expected_d = next_expected;
            case (state_q)
                ST_SEARCH: begin
                    match_d = '0;
                    state_d = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (!in_match) begin
                        match_d = '0;
                    end else if (match_inc == LOCK_MATCH) begin
                        match_d = '0;
                        state_d = ST_LOCKED;
                    end else begin
                        match_d = match_inc;
                    end
                end
                ST_LOCKED: begin
                    if (!in_match) begin
                        err_pulse_d = 1'b1;
                        err_count_d = (err_base == ERR_MAX) ? err_base : err_base + ERR_WIDTH'(1);
                        match_d     = '0;
                        state_d     = ST_ACQUIRE;
                    end
                end
                default: begin
                    match_d = '0;
                    state_d = ST_SEARCH;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SEARCH;
            match_q     <= '0;
            expected_q  <= '0;
            err_count_q <= '0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_q     <= match_d;
            expected_q  <= expected_d;
            err_count_q <= err_count_d;
            err_pulse_q <= err_pulse_d;
            locked_q    <= locked_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign expected  = expected_q;
    assign state     = state_q;

endmodule

// File: tb/tb_count_stream_checker.sv
// Scoreboard bench for count_stream_checker: directed samples push hand-computed
// responses; a monitor pops one per clock and compares every output.
module tb_count_stream_checker;

    localparam int W  = 8;
    localparam int LC = 4;
    localparam int EW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_count = '0;
    logic          clr_err = 1'b0;
    logic          locked;
    logic          err_pulse;
    logic [EW-1:0] err_count;
    logic [W-1:0]  expected;
    logic [1:0]    state;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]    st;
        logic          lk;
        logic          ep;
        logic [EW-1:0] ec;
        logic [W-1:0]  ex;
    } exp_t;

    exp_t exp_q[$];

    count_stream_checker #(.WIDTH(W), .LOCK_COUNT(LC), .ERR_WIDTH(EW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_count  (in_count),
        .clr_err   (clr_err),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .expected  (expected),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int vec, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s vec %0d: got %0d expected %0d", name, vec, act, req);
        end
    endtask

    // Monitor: every clock the DUT presents a registered response for the previous sample.
    initial begin : monitor
        int vec = 0;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state",     vec, int'(state),     int'(e.st));
                chk("locked",    vec, int'(locked),    int'(e.lk));
                chk("err_pulse", vec, int'(err_pulse), int'(e.ep));
                chk("err_count", vec, int'(err_count), int'(e.ec));
                chk("expected",  vec, int'(expected),  int'(e.ex));
                vec++;
            end
        end
    end

    task automatic v(input bit r, input bit val, input bit clr, input int cnt,
                     input int st, input int lk, input int ep, input int ec, input int ex);
        exp_t e;
        @(negedge clk);
        rst      = r;
        in_valid = val;
        clr_err  = clr;
        in_count = W'(cnt);
        e.st = 2'(st);
        e.lk = 1'(lk);
        e.ep = 1'(ep);
        e.ec = EW'(ec);
        e.ex = W'(ex);
        exp_q.push_back(e);
    endtask

    task automatic s(input int cnt, input int st, input int lk, input int ep, input int ec, input int ex);
        v(1'b0, 1'b1, 1'b0, cnt, st, lk, ep, ec, ex);
    endtask

    task automatic idle(input int st, input int lk, input int ec, input int ex);
        v(1'b0, 1'b0, 1'b0, 0, st, lk, 0, ec, ex);
    endtask

    task automatic do_reset();
        v(1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    endtask

    // After an error or seed, four consecutive values starting at the expected one relock.
    task automatic relock(input int start, input int ec);
        s(start,     1, 0, 0, ec, (start + 1) % 256);
        s(start + 1, 1, 0, 0, ec, (start + 2) % 256);
        s(start + 2, 1, 0, 0, ec, (start + 3) % 256);
        s(start + 3, 2, 1, 0, ec, (start + 4) % 256);
    endtask

    initial begin : stim
        int n;
        do_reset();
        do_reset();

        // Seed and lock
        s(10, 1, 0, 0, 0, 11);
        s(11, 1, 0, 0, 0, 12);
        s(12, 1, 0, 0, 0, 13);
        s(13, 1, 0, 0, 0, 14);
        s(14, 2, 1, 0, 0, 15);
        idle(2, 1, 0, 15);

        // Wrap-around while locked
        do_reset();
        s(248, 1, 0, 0, 0, 249);
        relock(249, 0);
        s(253, 2, 1, 0, 0, 254);
        s(254, 2, 1, 0, 0, 255);
        s(255, 2, 1, 0, 0, 0);
        s(0,   2, 1, 0, 0, 1);
        s(1,   2, 1, 0, 0, 2);

        // Single error while locked, then relock
        do_reset();
        s(35, 1, 0, 0, 0, 36);
        relock(36, 0);
        s(45, 1, 0, 1, 1, 46);
        idle(1, 0, 1, 46);
        relock(46, 1);

        // Mismatch during ACQUIRE restarts the run without counting an error
        do_reset();
        s(5,  1, 0, 0, 0, 6);
        s(6,  1, 0, 0, 0, 7);
        s(9,  1, 0, 0, 0, 10);
        s(10, 1, 0, 0, 0, 11);
        s(11, 1, 0, 0, 0, 12);
        s(12, 1, 0, 0, 0, 13);
        s(13, 2, 1, 0, 0, 14);

        // Saturation of a 2-bit error counter, including stall and backwards values
        s(100, 1, 0, 1, 1, 101);
        relock(101, 1);
        s(104, 1, 0, 1, 2, 105);
        relock(105, 2);
        s(50, 1, 0, 1, 3, 51);
        relock(51, 3);
        s(200, 1, 0, 1, 3, 201);
        relock(201, 3);
        s(7, 1, 0, 1, 3, 8);
        relock(8, 3);

        // Clear coincident with an error, then clear alone
        v(1'b0, 1'b1, 1'b1, 30, 1, 0, 1, 1, 31);
        v(1'b0, 1'b0, 1'b1, 0,  1, 0, 0, 0, 31);

        // Gapped valid stream, then reset mid-stream
        relock(31, 0);
        idle(2, 1, 0, 35);
        idle(2, 1, 0, 35);
        s(35, 2, 1, 0, 0, 36);
        idle(2, 1, 0, 36);
        idle(2, 1, 0, 36);
        s(36, 2, 1, 0, 0, 37);
        idle(2, 1, 0, 37);
        idle(2, 1, 0, 37);
        s(37, 2, 1, 0, 0, 38);
        v(1'b1, 1'b1, 1'b0, 99, 0, 0, 0, 0, 0);
        s(77, 1, 0, 0, 0, 78);

        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
